program_memory_loader: RTL
==========================

Name: program_memory_loader

Overview:
- Boot-time writer for the instruction memory that the single-cycle RISC-V core reads.
- Accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit words.
- Issues one-cycle write strobes to the program memory write port.
- Holds the core in reset until a complete, checksum-verified image has been loaded.

Parameters:
- PROGRAM_MEMORY_DEPTH, 64, maximum number of 32-bit words accepted.
- BASE_ADDRESS, 32'h0040_0000, byte address of word 0; same address space as the PC.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low reset.
- Byte_Data_i  input  8  stream byte.
- Byte_Valid_i  input  1  Byte_Data_i is valid.
- Byte_Ready_o  output  1  loader accepts a byte this cycle.
- Mem_Write_o  output  1  program memory write strobe, one cycle per word.
- Mem_Address_o  output  32  byte address of the word being written, word-aligned.
- Mem_Data_o  output  32  word being written.
- Core_Reset_o  output  1  active-low reset for the core; 0 until the image is accepted.
- Done_o  output  1  image loaded and verified.
- Error_o  output  1  length or checksum failure.
- Word_Count_o  output  $clog2(PROGRAM_MEMORY_DEPTH)+1  words written so far.

Behaviour:
- Reset (reset==0 at a clk edge):
  - State goes to LEN; byte index, word counter, length and running sum are cleared.
  - All outputs are 0, except Byte_Ready_o, which is 1 from the first cycle after reset.
  - Reset mid-load aborts the load and restarts at LEN.
  - Memory contents already written are not cleared.
- Handshake: a byte transfers on a clk edge where Byte_Valid_i && Byte_Ready_o.
  - Byte_Ready_o = 1 in LEN, DATA and CSUM; 0 otherwise.
  - Sustained throughput is 1 byte per cycle; the loader never back-pressures inside those states.
- Frame format: 4 length bytes (word count N, little-endian), then 4*N data bytes (little-endian words), then 1 checksum byte.
- Checksum rule: the 8-bit sum of every byte in the frame, including length and checksum bytes, must equal 8'h00.
- State LEN: collects 4 bytes. On the 4th byte:
  - N > PROGRAM_MEMORY_DEPTH -> ERROR.
  - N == 0 -> CSUM.
  - Otherwise -> DATA.
  - N is compared as a full 32-bit unsigned value.
- State DATA: byte k of a word lands in bits [8k+7:8k].
  - On the cycle after the 4th byte is accepted:
    - Mem_Write_o = 1 for exactly one cycle.
    - Mem_Address_o = BASE_ADDRESS + 4*index.
    - Mem_Data_o = assembled word.
  - Word_Count_o increments in that same cycle.
  - The output registers hold their values between strobes.
  - After word N-1 is accepted -> CSUM.
- State CSUM: accepts 1 byte.
  - Final sum == 0 -> DONE.
  - Otherwise -> ERROR.
- DONE:
  - Done_o = 1 and Core_Reset_o = 1, both registered and asserted the cycle DONE is entered.
  - Byte_Ready_o = 0; extra bytes are ignored.
  - Terminal until reset.
- ERROR:
  - Error_o = 1; Core_Reset_o stays 0; Byte_Ready_o = 0.
  - Terminal until reset.
  - Words written before the failure remain in memory; the core never executes them.
- Simultaneity:
  - The final data word's write strobe coincides with the CSUM byte if that byte arrives immediately. Both must be handled: the write completes and the checksum is evaluated.
  - Done_o never asserts before the last Mem_Write_o pulse.

Decomposition:
- Shared package (loader_pkg): state encoding (LEN, DATA, CSUM, DONE, ERROR), frame-length constant 4, checksum width 8.
- One natural sub-module: byte_to_word_assembler.
  - Function: shift/placement register, 2-bit byte index, word-complete pulse.
  - Reuse: used for both the length field and the data words.
- The FSM, address generation and checksum accumulator live in the top.

Test Plan:
- Nominal 2-word image:
  - Stream: 02 00 00 00 | 13 05 50 00 | 93 05 A0 00 | 5E, back-to-back.
  - Expect two Mem_Write_o pulses: 0x00400000 <- 0x00500513, then 0x00400004 <- 0x00A00593.
  - Expect Word_Count_o = 2, then Done_o = 1 and Core_Reset_o = 1.
- Same image with Byte_Valid_i toggled every other cycle -> identical writes, addresses and final flags; no byte duplicated or dropped.
- Bad checksum: same stream with last byte 5F -> both writes occur, then Error_o = 1, Core_Reset_o remains 0, Byte_Ready_o = 0.
- Oversize length: 41 00 00 00 with depth 64 (N = 65) -> Error_o = 1 right after the 4th byte, no Mem_Write_o pulse ever.
- Zero length: 00 00 00 00 00 -> Done_o = 1 with no writes. Then 00 00 00 00 01 (after a fresh reset) -> Error_o = 1.
- Reset mid-load: pulse reset low after 6 bytes of the nominal image, then send the full nominal stream -> outputs clear during reset, and the exact nominal write sequence and Done_o follow.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared definitions for the boot-time program memory loader: frame layout,
// checksum width and the loader state encoding.
package loader_pkg;

  localparam int FRAME_LEN_BYTES = 4;
  localparam int CSUM_W          = 8;
  localparam int BYTE_IDX_W      = $clog2(FRAME_LEN_BYTES);

  typedef enum logic [2:0] {
    ST_LEN   = 3'd0,
    ST_DATA  = 3'd1,
    ST_CSUM  = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERROR = 3'd4
  } state_t;

  // The loader only takes stream bytes while a frame is still being parsed.
  function automatic logic accepts_bytes(input state_t s);
    return (s == ST_LEN) || (s == ST_DATA) || (s == ST_CSUM);
  endfunction

endpackage

// File: rtl/byte_to_word_assembler.sv
// Places accepted bytes little-endian into a 32-bit word and pulses when the
// fourth byte of a word is accepted; word_o already includes that byte.
module byte_to_word_assembler
  import loader_pkg::*;
(
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           byte_accept_i,
  input  logic [7:0]                     byte_i,
  output logic [8*FRAME_LEN_BYTES-1:0]   word_o,
  output logic                           word_done_o
);

  logic [8*FRAME_LEN_BYTES-1:0] word_q, word_d;
  logic [BYTE_IDX_W-1:0]        idx_q, idx_d;

  always_comb begin
    word_d = word_q;
    idx_d  = idx_q;
    if (byte_accept_i) begin
      word_d[8*idx_q +: 8] = byte_i;
      idx_d                = idx_q + BYTE_IDX_W'(1);
    end
  end

  assign word_o      = word_d;
  assign word_done_o = byte_accept_i && (idx_q == BYTE_IDX_W'(FRAME_LEN_BYTES - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      word_q <= '0;
      idx_q  <= '0;
    end else begin
      word_q <= word_d;
      idx_q  <= idx_d;
    end
  end

endmodule

// File: rtl/program_memory_loader.sv
// Loads a length-prefixed, checksummed byte image into program memory and
// releases the core from reset only after the whole image verifies.
module program_memory_loader
  import loader_pkg::*;
#(
  parameter int          PROGRAM_MEMORY_DEPTH = 64,
  parameter logic [31:0] BASE_ADDRESS         = 32'h0040_0000,
  localparam int         WCW                  = $clog2(PROGRAM_MEMORY_DEPTH) + 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [7:0]     Byte_Data_i,
  input  logic           Byte_Valid_i,
  output logic           Byte_Ready_o,
  output logic           Mem_Write_o,
  output logic [31:0]    Mem_Address_o,
  output logic [31:0]    Mem_Data_o,
  output logic           Core_Reset_o,
  output logic           Done_o,
  output logic           Error_o,
  output logic [WCW-1:0] Word_Count_o,
  output state_t         State_o
);

  // Byte transfer: Byte_Valid_i && Byte_Ready_o at a rising clk edge moves one
  // byte; Byte_Ready_o depends only on state, never on Byte_Valid_i.
  state_t              state_q, state_d;
  logic [WCW-1:0]      len_q, len_d, count_q, count_d;
  logic [CSUM_W-1:0]   sum_q, sum_d, sum_next;
  logic                write_q, write_d;
  logic [31:0]         addr_q, addr_d, data_q, data_d;
  logic                accept, word_done;
  logic [31:0]         word;

  assign Byte_Ready_o = accepts_bytes(state_q);
  assign accept       = Byte_Valid_i && Byte_Ready_o;
  assign sum_next     = sum_q + Byte_Data_i;

  byte_to_word_assembler u_asm (
    .clk          (clk),
    .reset        (reset),
    .byte_accept_i(accept),
    .byte_i       (Byte_Data_i),
    .word_o       (word),
    .word_done_o  (word_done)
  );

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    count_d = count_q;
    sum_d   = sum_q;
    write_d = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    if (accept) sum_d = sum_next;
    case (state_q)
      ST_LEN: begin
        if (word_done) begin
          // Full 32-bit compare so huge lengths cannot alias into range.
          if (word > 32'(PROGRAM_MEMORY_DEPTH)) begin
            state_d = ST_ERROR;
          end else begin
            len_d   = word[WCW-1:0];
            state_d = (word == 32'd0) ? ST_CSUM : ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (word_done) begin
          write_d = 1'b1;
          addr_d  = BASE_ADDRESS + (32'(count_q) << 2);
          data_d  = word;
          count_d = count_q + WCW'(1);
          if (count_d == len_q) state_d = ST_CSUM;
        end
      end
      ST_CSUM: begin
        if (accept) state_d = (sum_next == '0) ? ST_DONE : ST_ERROR;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_LEN;
      len_q   <= '0;
      count_q <= '0;
      sum_q   <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      count_q <= count_d;
      sum_q   <= sum_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign Mem_Write_o   = write_q;
  assign Mem_Address_o = addr_q;
  assign Mem_Data_o    = data_q;
  assign Done_o        = (state_q == ST_DONE);
  assign Core_Reset_o  = (state_q == ST_DONE);
  assign Error_o       = (state_q == ST_ERROR);
  assign Word_Count_o  = count_q;
  assign State_o       = state_q;

endmodule
